wallace_mult_pipe: RTL and testbench

//   Parametrised WIDTH x WIDTH multiplier with a 3-stage pipeline and a valid/ready stream on both sides.

---
 rtl/wallace_mult_pipe.sv | 127 ++++++++++++
 tb/tb_wallace_mult_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mult_pipe.sv
// WIDTH x WIDTH multiplier with a 3-stage valid/ready pipeline: capture, Wallace carry-save
// reduction (unsigned or Baugh-Wooley signed), and a final carry-propagate add.
module wallace_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int P     = 2 * WIDTH;
  localparam int NROWS = WIDTH + 1;  // WIDTH partial products plus the Baugh-Wooley constant row

  // Rows left after a given number of Wallace levels: each full triple becomes two rows.
  function automatic int rows_after(input int lvl);
    int n;
    n = NROWS;
    for (int i = 0; i < lvl; i++) n = (n / 3) * 2 + (n % 3);
    return n;
  endfunction

  function automatic int tree_depth();
    int n;
    int d;
    n = NROWS;
    d = 0;
    for (int i = 0; i < NROWS; i++) begin
      if (n > 2) begin
        n = (n / 3) * 2 + (n % 3);
        d++;
      end
    end
    return d;
  endfunction

  localparam int LEVELS = tree_depth();

  // Builds the partial-product matrix and reduces it to a {sum, carry} pair.
  function automatic logic [2*P-1:0] wallace_reduce(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic             sgn);
    logic [P-1:0] t [0:LEVELS][0:NROWS-1];
    logic [P-1:0] r0, r1, r2;
    logic         bit_pp;
    int           cnt;
    int           ngrp;
    for (int l = 0; l <= LEVELS; l++)
      for (int r = 0; r < NROWS; r++) t[l][r] = '0;

    // Signed mode inverts terms where exactly one factor is a sign bit.
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        bit_pp = x[j] & y[i];
        if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) bit_pp = ~bit_pp;
        t[0][i][i+j] = bit_pp;
      end
    end
    t[0][WIDTH][WIDTH] = sgn;
    t[0][WIDTH][P-1]   = sgn;

    for (int l = 0; l < LEVELS; l++) begin
      cnt  = rows_after(l);
      ngrp = cnt / 3;
      for (int g = 0; g < NROWS / 3; g++) begin
        if (g < ngrp) begin
          r0 = t[l][3*g];
          r1 = t[l][3*g+1];
          r2 = t[l][3*g+2];
          t[l+1][2*g]   = r0 ^ r1 ^ r2;
          t[l+1][2*g+1] = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
        end
      end
      for (int k = 0; k < 2; k++)
        if (k < cnt % 3) t[l+1][2*ngrp+k] = t[l][3*ngrp+k];
    end
    return {t[LEVELS][0], t[LEVELS][1]};
  endfunction

  logic               adv;
  logic               v1, v2;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               sgn_r;
  logic [P-1:0]       sum_d, carry_d;
  logic [P-1:0]       sum_r, carry_r;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // NOTE: combinational outputs get a full assignment on every path so no latch is inferred.
  always_comb begin
    {sum_d, carry_d} = wallace_reduce(a_r, b_r, sgn_r);
  end

  // NOTE: state uses non-blocking assignments so every stage samples the pre-edge value of
  // the stage before it; blocking here would collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sgn_r     <= 1'b0;
      v2        <= 1'b0;
      sum_r     <= '0;
      carry_r   <= '0;
      out_valid <= 1'b0;
      product   <= '0;
    end else if (adv) begin
      v1        <= in_valid && in_ready;
      a_r       <= a;
      b_r       <= b;
      sgn_r     <= is_signed;
      v2        <= v1;
      sum_r     <= sum_d;
      carry_r   <= carry_d;
      out_valid <= v2;
      product   <= sum_r + carry_r;
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench for wallace_mult_pipe (WIDTH=8): directed vectors, stream, backpressure,
// mid-flight reset and a full operand sweep with mixed modes, all through a scoreboard queue.
module tb_wallace_mult_pipe;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           is_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] product;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          out_stamp[$];

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [8] = '{
    '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
    '{8'h00, 8'hAB, 1'b0, 16'h0000},
    '{8'h80, 8'h80, 1'b1, 16'h4000},
    '{8'hFF, 8'h01, 1'b1, 16'hFFFF},
    '{8'h7F, 8'h80, 1'b1, 16'hC080},
    '{8'h80, 8'h80, 1'b0, 16'h4000},
    '{8'hFF, 8'h01, 1'b0, 16'h00FF},
    '{8'h7F, 8'h80, 1'b0, 16'h3F80}
  };

  always #5 clk = ~clk;

  wallace_mult_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, got, expv, cyc);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                          input logic s);
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    sx = {{8{x[7]}}, x};
    sy = {{8{y[7]}}, y};
    if (s) return sx * sy;
    return {8'h00, x} * {8'h00, y};
  endfunction

  // Output monitor: every accepted product is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        check("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
        out_stamp.push_back(cyc);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the edge that accepted the pair.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                      input logic [15:0] texp);
    logic rdy;
    int   guard;
    guard     = 0;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    is_signed = ts;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 200);
    if (!rdy) check("send_timeout", {31'd0, in_ready}, 32'd1);
    else exp_q.push_back(texp);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] x;
    logic [7:0] y;

    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    sync();

    // Single transaction latency and hold-through-bubbles
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    check("latency", k, 32'd3);
    check("ff_x_ff", {16'd0, product}, 32'h0000FE01);
    repeat (3) @(negedge clk);
    check("bubble_out_valid", {31'd0, out_valid}, 32'd0);
    check("bubble_hold", {16'd0, product}, 32'h0000FE01);

    // Directed boundary vectors, back to back
    sync();
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
    in_valid = 1'b0;
    drain();

    // 256 random pairs, alternating mode, one result per cycle
    out_stamp.delete();
    sync();
    for (int i = 0; i < 256; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      send(x, y, i[0], ref_mul(x, y, i[0]));
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", out_stamp.size(), 32'd256);
    if (out_stamp.size() > 0)
      check("stream_span", out_stamp[out_stamp.size()-1] - out_stamp[0], 32'd255);

    // Backpressure with three pairs in flight
    sync();
    send(8'h12, 8'h34, 1'b0, 16'h03A8);
    send(8'hFE, 8'h03, 1'b1, 16'hFFFA);
    send(8'h10, 8'h10, 1'b0, 16'h0100);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_full_valid", {31'd0, out_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_product", {16'd0, product}, 32'h000003A8);
    end
    sync();
    out_ready = 1'b1;
    drain();

    // Reset with two pairs in flight
    sync();
    send(8'h21, 8'h02, 1'b0, 16'h0042);
    send(8'h81, 8'h7F, 1'b1, 16'hC0FF);
    in_valid = 1'b0;
    sync();
    check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_product", {16'd0, product}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync();
    send(8'h03, 8'h05, 1'b0, 16'h000F);
    in_valid = 1'b0;
    drain();

    // Full operand sweep; mode follows operand LSB parity so both modes are exercised
    sync();
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib++) begin
        x = 8'(ia);
        y = 8'(ib);
        send(x, y, x[0] ^ y[0], ref_mul(x, y, x[0] ^ y[0]));
      end
    end
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
